nonce_result_fifo: RTL

- Buffers nonce-search results from the nonce decoder until the host-side reader drains them.
- Sits directly downstream of the miner top's decoder outputs (result valid, success, nonce, new-block).
- Decouples the single-cycle decoder result pulses from a ready/valid reader.
- Provides a sticky overflow flag, which is the value the miner drives onto the nonce buffer's overflow line.

---
 rtl/bcminer_pkg.sv | 12 +
 rtl/nonce_result_fifo_if.sv | 31 +++
 rtl/nonce_result_mem.sv | 24 ++
 rtl/nonce_result_fifo.sv | 104 ++++++++++
 4 files changed

// File: rtl/bcminer_pkg.sv
// Shared types and constants for the nonce result path of the miner.
package bcminer_pkg;

    localparam int unsigned NONCE_W_DEFAULT = 32;

    // One decoder result as held in the result buffer.
    typedef struct packed {
        logic                       success;
        logic [NONCE_W_DEFAULT-1:0] nonce;
    } nonce_entry_t;

endpackage

// File: rtl/nonce_result_fifo_if.sv
// Decoder-write / reader-drain bundle of the nonce result buffer.
interface nonce_result_fifo_if
    import bcminer_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NONCE_W = NONCE_W_DEFAULT
);
    logic                         newblock_i;
    logic                         wr_valid_i;
    logic                         wr_success_i;
    logic [NONCE_W-1:0]           wr_nonce_i;
    logic                         rd_ready_i;
    logic                         rd_valid_o;
    logic                         rd_success_o;
    logic [NONCE_W-1:0]           rd_nonce_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         full_o;
    logic                         overflow_o;

    // Buffer side.
    modport slave (
        input  newblock_i, wr_valid_i, wr_success_i, wr_nonce_i, rd_ready_i,
        output rd_valid_o, rd_success_o, rd_nonce_o, count_o, full_o, overflow_o
    );

    // Decoder / reader side.
    modport master (
        output newblock_i, wr_valid_i, wr_success_i, wr_nonce_i, rd_ready_i,
        input  rd_valid_o, rd_success_o, rd_nonce_o, count_o, full_o, overflow_o
    );
endinterface

// File: rtl/nonce_result_mem.sv
// Register array for the result buffer: one synchronous write port, one
// asynchronous read port, data not reset.
module nonce_result_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 33
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    // Store the write data into the addressed slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/nonce_result_fifo.sv
// First-word-fall-through buffer of nonce decoder results with a sticky
// overflow flag; flushed on every new block.
module nonce_result_fifo
    import bcminer_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NONCE_W = NONCE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    nonce_result_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = NONCE_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;

    logic             pop;
    logic             push;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [ENT_W-1:0] head;

    assign pop  = (count_q != '0) && bus.rd_ready_i;
    assign push = bus.wr_valid_i && ((count_q < CNT_W'(DEPTH)) || pop);

    // Next-state pointers, occupancy and overflow flag. A flush restarts the
    // buffer and, if a write arrives with it, places that write in slot 0.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = wptr_q;
        if (bus.newblock_i) begin
            rptr_d     = '0;
            overflow_d = 1'b0;
            mem_waddr  = '0;
            mem_we     = bus.wr_valid_i;
            wptr_d     = bus.wr_valid_i ? PTR_W'(1) : '0;
            count_d    = bus.wr_valid_i ? CNT_W'(1) : '0;
        end else begin
            mem_we = push;
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (bus.wr_valid_i && !push) begin
                overflow_d = 1'b1;
            end
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    nonce_result_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i ({bus.wr_success_i, bus.wr_nonce_i}),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    // Head is masked while empty so the unreset array never shows through.
    assign bus.rd_valid_o   = (count_q != '0);
    assign bus.rd_success_o = bus.rd_valid_o ? head[ENT_W-1] : 1'b0;
    assign bus.rd_nonce_o   = bus.rd_valid_o ? head[NONCE_W-1:0] : '0;
    assign bus.count_o      = count_q;
    assign bus.full_o       = full_q;
    assign bus.overflow_o   = overflow_q;
endmodule
